// File: rtl/fp8_pkg.sv
// E4M3 constants, operand classes and stage bundles shared by the FP8 units.
// Subnormal support in the datapath is selected with FP8_SUBNORM_EN.
package fp8_pkg;

  localparam int         E4M3_BIAS = 7;
  localparam logic [7:0] E4M3_MAX  = 8'h7E;
  localparam logic [7:0] E4M3_NAN  = 8'h7F;

  localparam int FLAG_NAN = 3;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

  typedef enum logic [1:0] {
    ZERO,
    SUB,
    NORM,
    NAN
  } fp8_cls_e;

  typedef struct packed {
    logic       sign;
    logic [3:0] exp;
    logic [3:0] sig;
    fp8_cls_e   cls;
  } fp8_op_t;

  typedef struct packed {
    logic              sign;
    logic              nan;
    logic              zero;
    logic signed [5:0] exp;
    logic [3:0]        sig_a;
    logic [3:0]        sig_b;
  } s1_t;

  typedef struct packed {
    logic              sign;
    logic              nan;
    logic              zero;
    logic signed [6:0] exp;
    logic [3:0]        man;
    logic              guard;
    logic              sticky;
  } s2_t;

  // Subnormals keep exponent 1 with a zero implicit bit.
  function automatic fp8_op_t fp8_unpack(
    input logic [7:0] x
  );
    fp8_op_t o;
    o.sign = x[7];
    o.exp  = (x[6:3] == 4'd0) ? 4'd1 : x[6:3];
    o.sig  = {|x[6:3], x[2:0]};
    unique case (1'b1)
      x[6:0] == 7'h7F:
        o.cls = NAN;
      x[6:0] == 7'h00:
        o.cls = ZERO;
      (x[6:3] == 4'd0) && (x[2:0] != 3'd0):
        o.cls = SUB;
      default:
        o.cls = NORM;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/fp8_round_pack.sv
// Round-to-nearest-even, overflow/underflow selection and E4M3 packing.
// With FP8_SUBNORM_EN tiny results are denormalized instead of flushed.
module fp8_round_pack
  import fp8_pkg::*;
#(
  parameter bit SATURATE = 1'b1
)(
  input  logic              sign,
  input  logic              nan,
  input  logic              zero,
  input  logic signed [6:0] exp,
  input  logic [3:0]        man,
  input  logic              guard,
  input  logic              sticky,
  output logic [7:0]        res,
  output logic [3:0]        flags
);

  logic signed [6:0] be;
  logic signed [6:0] re;
  logic [4:0]        rman;
  logic [2:0]        rm;
  logic              rnd_up;
  logic              inx;
  logic              tiny;
  logic              ovf;

  always_comb begin
    be     = exp + signed'(7'(E4M3_BIAS));
    rnd_up = guard & (sticky | man[0]);
    rman   = {1'b0, man} + {4'b0000, rnd_up};
    re     = rman[4] ? be + 7'sd1 : be;
    rm     = rman[2:0];
    inx    = guard | sticky;
    tiny   = be < 7'sd1;
    ovf    = (re > 7'sd15) ||
             ((re == 7'sd15) && (rm == 3'b111));
  end

`ifdef FP8_SUBNORM_EN
  logic signed [6:0] sh_s;
  logic [3:0]        sh;
  logic [9:0]        den;
  logic              sub_g;
  logic              sub_st;
  logic              sub_inx;
  logic [3:0]        sub_m;

  // Align to the 2^-6 subnormal scale; the guard bit rides along.
  always_comb begin
    sh_s    = 7'sd1 - be;
    sh      = (sh_s > 7'sd9) ? 4'd9 : sh_s[3:0];
    den     = {man, guard, 5'b00000} >> sh;
    sub_g   = den[5];
    sub_st  = sticky | (|den[4:0]);
    sub_m   = den[9:6] +
              {3'b000, sub_g & (sub_st | den[6])};
    sub_inx = sub_g | sub_st;
  end
`endif

  always_comb begin
    res   = '0;
    flags = '0;
    if (nan) begin
      res             = E4M3_NAN;
      flags[FLAG_NAN] = 1'b1;
    end else if (zero) begin
      res = {sign, 7'd0};
    end else if (tiny) begin
`ifdef FP8_SUBNORM_EN
      res             = {sign, 3'b000, sub_m};
      flags[FLAG_UNF] = sub_inx;
      flags[FLAG_INX] = sub_inx;
`else
      res             = {sign, 7'd0};
      flags[FLAG_UNF] = 1'b1;
      flags[FLAG_INX] = 1'b1;
`endif
    end else if (ovf) begin
      res = SATURATE ? {sign, E4M3_MAX[6:0]}
                     : {sign, E4M3_NAN[6:0]};
      flags[FLAG_OVF] = 1'b1;
      flags[FLAG_INX] = 1'b1;
    end else begin
      res             = {sign, re[3:0], rm};
      flags[FLAG_INX] = inx;
    end
  end

endmodule

// File: rtl/fp8_mul_pipe.sv
// Three-stage E4M3 multiplier with valid/ready on both sides and a tag sideband.
// Define FP8_SUBNORM_EN to use subnormals at true value instead of FTZ.
module fp8_mul_pipe
  import fp8_pkg::*;
#(
  parameter int TAG_W    = 4,
  parameter bit SATURATE = 1'b1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags
);

  logic             rdy_q;
  logic             s1_valid;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic             s3_adv;
  logic             accept;
  s1_t              s1_d;
  s1_t              s1_q;
  s2_t              s2_d;
  s2_t              s2_q;
  logic [TAG_W-1:0] s1_tag;
  logic [TAG_W-1:0] s2_tag;
  fp8_op_t          ua;
  fp8_op_t          ub;
  logic [7:0]       prod;
  logic [7:0]       norm;
  logic signed [6:0] nexp;
  logic [7:0]       res;
  logic [3:0]       flags;

  assign s3_adv   = !out_valid || out_ready;
  assign s2_adv   = !s2_valid || s3_adv;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = rdy_q && s1_adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    ua         = fp8_unpack(in_a);
    ub         = fp8_unpack(in_b);
    s1_d       = '0;
    s1_d.sign  = ua.sign ^ ub.sign;
    s1_d.nan   = (ua.cls == NAN) || (ub.cls == NAN);
`ifdef FP8_SUBNORM_EN
    s1_d.zero  = (ua.cls == ZERO) || (ub.cls == ZERO);
`else
    s1_d.zero  = (ua.cls inside {ZERO, SUB}) ||
                 (ub.cls inside {ZERO, SUB});
`endif
    s1_d.exp   = signed'({2'b00, ua.exp} +
                         {2'b00, ub.exp} - 6'd14);
    s1_d.sig_a = ua.sig;
    s1_d.sig_b = ub.sig;
  end

  always_comb begin
    prod = {4'b0000, s1_q.sig_a} * {4'b0000, s1_q.sig_b};
    norm = prod;
    nexp = {s1_q.exp[5], s1_q.exp};
    if (prod[7]) begin
      norm = prod >> 1;
      nexp = nexp + 7'sd1;
    end
`ifdef FP8_SUBNORM_EN
    // Subnormal operands can leave the leading one below bit 6.
    for (int i = 0; i < 6; i++) begin
      if (!norm[6]) begin
        norm = norm << 1;
        nexp = nexp - 7'sd1;
      end
    end
`endif
    s2_d        = '0;
    s2_d.sign   = s1_q.sign;
    s2_d.nan    = s1_q.nan;
    s2_d.zero   = s1_q.zero;
    s2_d.exp    = nexp;
    s2_d.man    = norm[6:3];
    s2_d.guard  = norm[2];
    s2_d.sticky = (|norm[1:0]) | (prod[7] & prod[0]);
  end

  fp8_round_pack #(
    .SATURATE(SATURATE)
  ) u_round_pack (
    .sign  (s2_q.sign),
    .nan   (s2_q.nan),
    .zero  (s2_q.zero),
    .exp   (s2_q.exp),
    .man   (s2_q.man),
    .guard (s2_q.guard),
    .sticky(s2_q.sticky),
    .res   (res),
    .flags (flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q    <= 1'b0;
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s1_tag   <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_q   <= s1_d;
          s1_tag <= in_tag;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
      s2_tag   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_q   <= s2_d;
        s2_tag <= s1_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_tag   <= '0;
      out_flags <= '0;
    end else if (s3_adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_p     <= res;
        out_tag   <= s2_tag;
        out_flags <= flags;
      end
    end
  end

endmodule

// File: doc/fp8_mul_pipe.md
Name: fp8_mul_pipe

Overview:
- Three-stage pipelined FP8 (E4M3) multiplier with valid/ready handshake on both sides.
- Sits directly under the tt_um_lightFP8 top: the top wraps ui_in/uio_in operand bytes into in_a/in_b and drives uo_out from out_p.
- Carries a small tag per operation so the top can match results to requests.
- Provides IEEE-style status flags.

Parameters:
- TAG_W, 4, width of the sideband tag carried alongside each operation (min 1).
- SATURATE, 1: 1 = overflow produces ±448 (0x7E/0xFE); 0 = overflow produces NaN (0x7F/0xFF).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  pipeline accepts this cycle.
- in_a  in  8  operand A, E4M3 {s, e[3:0], m[2:0]}, bias 7.
- in_b  in  8  operand B, same format.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_p  out  8  product, E4M3.
- out_tag  out  TAG_W  tag of this result.
- out_flags  out  4  {nan, overflow, underflow, inexact}.

Behaviour:
- Format:
  - e=0: zero or subnormal; e=1..15: normal, value (1.m)·2^(e−7).
  - Only NaN encodings are 0x7F/0xFF. No infinities. Max finite ±448 (0x7E).
- Reset: all stage valids, out_valid, out_p, out_tag and out_flags are 0. in_ready is 1 one cycle after rst deasserts; in_ready is 0 while rst is high. Any operation in flight at reset is dropped.
- Handshakes:
  - Transfer occurs when valid&&ready.
  - Stage k advances when it is empty or stage k+1 advances. Stage 3 advances on out_ready.
  - in_ready = !s1_valid || s1_advance. This is a combinational path from out_ready through the stalls; no skid buffer.
  - out_valid/out_p/out_tag/out_flags hold stable while out_valid && !out_ready.
- Latency:
  - Exactly 3 cycles from the accept edge to out_valid when unstalled.
  - Throughput 1 operation per cycle.
- Stages:
  - S1: unpack and classify (zero/sub/normal/NaN). Sign = sa^sb. Unbiased exponent sum, 6-bit signed = ea+eb−14 (subnormal e treated as 1 with implicit bit 0).
  - S2: 4×4 significand multiply giving 8 bits. Normalize: if bit7 set, shift right 1 and increment exponent. Compute guard and sticky.
  - S3: round to nearest, ties to even, then pack. A mantissa carry-out on rounding increments the exponent. Pick overflow/underflow/result mux.
- Special cases, in priority order:
  - Any NaN input → 0x7F, nan=1.
  - Zero × finite → signed zero (sa^sb), no flags.
  - Overflow (exponent above 15 after rounding, or result 0x7F pattern) → per SATURATE, overflow=1, inexact=1.
  - Result below the min normal 2^−6 → underflow=1, and zero with sign is output (FTZ). Inexact is set if nonzero was lost. Subnormal inputs are treated as zero in FTZ mode.
- Simultaneous in accept and out release in the same cycle are both legal; nothing is lost or duplicated.

Optional Feature:
- Macro: FP8_SUBNORM_EN.
- Defined:
  - Subnormal inputs are used at their true value.
  - Results in [2^−9, 2^−6) are denormalized with a right shift and RNE rounding into e=0 encodings.
  - Underflow is flagged only when the result is tiny and inexact.
- Undefined: FTZ behaviour as above.
- Latency and handshake are identical in both builds.

Decomposition:
- Package fp8_pkg holds:
  - Constants: E4M3_BIAS=7, E4M3_MAX=8'h7E, E4M3_NAN=8'h7F.
  - Flag bit indices.
  - Class enum {ZERO, SUB, NORM, NAN}.
  - An unpacked-operand struct.
- Sub-module fp8_round_pack: combinational S3 rounding, saturation and packing. It is reused by the future adder stage.

Test Plan:
- Basic: 0x3C(1.5) × 0x40(2.0), tag 3 → 3 cycles later out_p=0x44(3.0), tag 3, flags 0000.
- RNE tie: 0x39(1.125) × 0x3C(1.5) → 0x3E(1.75), inexact=1. Sign: 0xB9 × 0x3C → 0xBE.
- Overflow: 0x7E × 0x40 → 0x7E, flags {0,1,0,1} with SATURATE=1; 0x7F with SATURATE=0. NaN: 0x7F × 0x00 → 0x7F, nan=1.
- Underflow: 0x08 × 0x30 (2^−6 × 0.5) → 0x00, underflow=1 (FTZ); with FP8_SUBNORM_EN → 0x04, flags 0000.
- Backpressure: stream 8 ops with tags 0..7, hold out_ready=0 for 5 cycles mid-stream → in_ready drops once 3 ops are stored. Results arrive in order, none lost or duplicated, and outputs stay stable while stalled.
- Reset mid-flight: assert rst asynchronously with 2 ops in flight → out_valid=0 immediately. After release, a new op 0x3C×0x40 emerges alone after 3 cycles.
